// File: rtl/cpu_pkg.sv
// Shared definitions for the Pipelined_CPU design: instruction field positions,
// opcode and condition-code values, pipeline register layout and decode helpers.
package cpu_pkg;

    localparam int MEM_DEPTH = 2048;
    localparam int AW        = 11;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int RIDX_W    = 6;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 29;
    localparam int CC_HI  = 26;
    localparam int CC_LO  = 24;
    localparam int IMM_B  = 23;
    localparam int DST_HI = 21;
    localparam int DST_LO = 11;
    localparam int SRC_HI = 10;
    localparam int SRC_LO = 0;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam logic [2:0] OP_STORE  = 3'b110;
    localparam logic [2:0] OP_LOAD   = 3'b111;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_Z      = 3'b001;
    localparam logic [2:0] CC_C      = 3'b010;
    localparam logic [2:0] CC_N      = 3'b011;
    localparam logic [2:0] CC_NZ     = 3'b100;
    localparam logic [2:0] CC_NC     = 3'b101;
    localparam logic [2:0] CC_NN     = 3'b110;
    localparam logic [2:0] CC_NEVER  = 3'b111;

    localparam logic [XLEN-1:0] NOP_WORD = '0;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
    } flags_t;

    // ID/EX register: decoded fields plus operand values captured in ID.
    typedef struct packed {
        logic [2:0]      op;
        logic [2:0]      cc;
        logic            imm;
        logic [AW-1:0]   dst;
        logic [AW-1:0]   src;
        logic [XLEN-1:0] dval;
        logic [XLEN-1:0] sval;
        logic [XLEN-1:0] mval;
    } id_ex_t;

    // Bank A occupies indices 0..31, bank B 32..63.
    function automatic logic [RIDX_W-1:0] reg_index(input logic [AW-1:0] operand);
        return operand[10] ? {1'b1, operand[9:5]} : {1'b0, operand[4:0]};
    endfunction

    function automatic logic cc_holds(input logic [2:0] cc, input flags_t f);
        logic holds;
        holds = 1'b0;
        case (cc)
            CC_ALWAYS: holds = 1'b1;
            CC_Z:      holds = f.z;
            CC_C:      holds = f.c;
            CC_N:      holds = f.n;
            CC_NZ:     holds = !f.z;
            CC_NC:     holds = !f.c;
            CC_NN:     holds = !f.n;
            CC_NEVER:  holds = 1'b0;
            default:   holds = 1'b0;
        endcase
        return holds;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: OR/AND/SUB/ADD with carry (borrow for SUB), zero and negative.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            c,
    output logic            z,
    output logic            n
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        res = '0;
        c   = 1'b0;
        case (op)
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_SUB: begin
                res = a - b;
                c   = (a < b);
            end
            OP_ADD: {c, res} = {1'b0, a} + {1'b0, b};
            default: ;
        endcase
        z = (res == '0);
        n = res[XLEN-1];
    end

endmodule

// File: rtl/top_level.sv
// Top of the Pipelined_CPU design: IF / ID / EX-WB pipeline around a unified
// memory that an external loader can write at any time.
module top_level
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            cpu_en,
    input  logic [XLEN-1:0] w_instruction,
    input  logic            w_enable,
    input  logic [AW-1:0]   w_adrs,
    output logic            carry,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] mem_q  [MEM_DEPTH];
    logic [XLEN-1:0] regs_q [2*NREG];

    logic [AW-1:0]   pc_q, pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    id_ex_t          ex_q, ex_d;
    flags_t          flags_q, flags_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0]   ex_s, alu_res, rf_wdata, mem_wdata;
    logic              alu_c, alu_z, alu_n;
    logic              ex_is_alu, ex_taken, rf_we, st_we, mem_we;
    logic [RIDX_W-1:0] rf_waddr, id_dst_idx, id_src_idx;
    logic [AW-1:0]     mem_waddr, id_src;
    logic              unused_rsvd;

    assign unused_rsvd = ^{if_instr_q[28:27], if_instr_q[22]};

    cpu_alu u_alu (
        .op  (ex_q.op),
        .a   (ex_q.dval),
        .b   (ex_s),
        .res (alu_res),
        .c   (alu_c),
        .z   (alu_z),
        .n   (alu_n)
    );

    // EX/WB: execute, write back, store, resolve branch.
    always_comb begin
        ex_s      = ex_q.imm ? XLEN'(ex_q.src) : ex_q.sval;
        ex_is_alu = ex_q.op inside {OP_OR, OP_AND, OP_SUB, OP_ADD};
        ex_taken  = (ex_q.op == OP_BRANCH) && cc_holds(ex_q.cc, flags_q);
        rf_we     = cpu_en && !resetn && (ex_is_alu || ex_q.op == OP_LOAD);
        rf_waddr  = reg_index(ex_q.dst);
        rf_wdata  = (ex_q.op == OP_LOAD) ? ex_q.mval : alu_res;
        // The loader owns the single write port; a colliding STORE is lost.
        st_we     = cpu_en && !resetn && (ex_q.op == OP_STORE) && !w_enable;
        mem_we    = w_enable || st_we;
        mem_waddr = w_enable ? w_adrs : ex_q.dst;
        mem_wdata = w_enable ? w_instruction : ex_q.sval;
    end

    // IF and ID, with EX results forwarded into the operands ID captures.
    always_comb begin
        id_src     = if_instr_q[SRC_HI:SRC_LO];
        id_dst_idx = reg_index(if_instr_q[DST_HI:DST_LO]);
        id_src_idx = reg_index(id_src);

        ex_d      = '0;
        ex_d.op   = if_instr_q[OP_HI:OP_LO];
        ex_d.cc   = if_instr_q[CC_HI:CC_LO];
        ex_d.imm  = if_instr_q[IMM_B];
        ex_d.dst  = if_instr_q[DST_HI:DST_LO];
        ex_d.src  = id_src;
        ex_d.dval = (rf_we && rf_waddr == id_dst_idx) ? rf_wdata : regs_q[id_dst_idx];
        ex_d.sval = (rf_we && rf_waddr == id_src_idx) ? rf_wdata : regs_q[id_src_idx];
        ex_d.mval = (st_we && ex_q.dst == id_src) ? ex_q.sval : mem_q[id_src];

        if_instr_d = mem_q[pc_q];
        pc_d       = pc_q + AW'(1);
        flags_d    = flags_q;
        result_d   = result_q;

        if (ex_is_alu) begin
            flags_d = '{z: alu_z, c: alu_c, n: alu_n};
        end
        if (rf_we) begin
            result_d = rf_wdata;
        end
        if (ex_taken) begin
            pc_d       = ex_q.src;
            if_instr_d = NOP_WORD;
            ex_d       = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (resetn) begin
            pc_q       <= '0;
            if_instr_q <= NOP_WORD;
            ex_q       <= '0;
            flags_q    <= '0;
            result_q   <= '0;
        end else if (cpu_en) begin
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            ex_q       <= ex_d;
            flags_q    <= flags_d;
            result_q   <= result_d;
        end
    end

    // NOTE: the memory deliberately has no reset; programs survive a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 2*NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign result = result_q;
    assign carry  = flags_q.c;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: an instruction-level reference model
// (sequential ISA semantics plus fill/flush latency) is compared every cycle.
module tb_top_level;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cpu_en = 1'b0;
    logic [31:0] w_instruction = '0;
    logic        w_enable = 1'b0;
    logic [10:0] w_adrs = '0;
    logic        carry;
    logic [31:0] result;

    always #5 clk = ~clk;

    top_level dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_en        (cpu_en),
        .w_instruction (w_instruction),
        .w_enable      (w_enable),
        .w_adrs        (w_adrs),
        .carry         (carry),
        .result        (result)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_mem [2048];
    logic [31:0] m_reg [64];
    bit          m_z, m_c, m_n;
    logic [31:0] m_res;
    int          m_pc, m_dead;

    bit          cap_on = 1'b0;
    logic [31:0] cap_last;
    logic [31:0] cap_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ridx(input int o);
        return (o >= 1024) ? 32 + ((o / 32) % 32) : o % 32;
    endfunction

    function automatic bit cond(input int cc);
        case (cc)
            0: return 1'b1;
            1: return m_z;
            2: return m_c;
            3: return m_n;
            4: return !m_z;
            5: return !m_c;
            6: return !m_n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_exec();
        logic [31:0] ins, d, s, r;
        logic [32:0] wide;
        int op, cc, dsti, srci;
        bit imm;
        ins  = m_mem[m_pc];
        m_pc = (m_pc + 1) % 2048;
        op   = int'(ins >> 29);
        cc   = int'((ins >> 24) & 32'h7);
        imm  = ((ins >> 23) & 32'h1) != 0;
        dsti = int'((ins >> 11) & 32'h7FF);
        srci = int'(ins & 32'h7FF);
        d    = m_reg[ridx(dsti)];
        s    = imm ? 32'(srci) : m_reg[ridx(srci)];
        if (op >= 1 && op <= 4) begin
            wide = {1'b0, d} + {1'b0, s};
            case (op)
                1: begin r = d | s; m_c = 1'b0; end
                2: begin r = d & s; m_c = 1'b0; end
                3: begin r = d - s; m_c = (d < s); end
                default: begin r = wide[31:0]; m_c = wide[32]; end
            endcase
            m_reg[ridx(dsti)] = r;
            m_res = r;
            m_z   = (r == 0);
            m_n   = r[31];
        end else if (op == 5) begin
            if (cond(cc)) begin
                m_pc   = srci;
                m_dead = 2;
            end
        end else if (op == 6) begin
            if (!w_enable) m_mem[dsti] = m_reg[ridx(srci)];
        end else if (op == 7) begin
            m_reg[ridx(dsti)] = m_mem[srci];
            m_res = m_mem[srci];
        end
    endtask

    task automatic model_step();
        if (resetn) begin
            for (int i = 0; i < 64; i++) m_reg[i] = '0;
            m_z = 0; m_c = 0; m_n = 0;
            m_res  = '0;
            m_pc   = 0;
            m_dead = 2;
        end else if (cpu_en) begin
            if (m_dead > 0) m_dead--;
            else model_exec();
        end
        if (w_enable) m_mem[w_adrs] = w_instruction;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("result", result, m_res);
        check("carry", {31'b0, carry}, {31'b0, m_c});
        if (cap_on && result !== cap_last) begin
            cap_q.push_back(result);
            cap_last = result;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        w_enable      = 1'b1;
        w_adrs        = 11'(a);
        w_instruction = d;
        tick();
        w_enable = 1'b0;
    endtask

    task automatic halt_and_reset();
        cpu_en = 1'b0;
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    function automatic logic [31:0] enc(input int op, input int cc, input int imm,
                                        input int dst, input int src);
        return (32'(op) << 29) | (32'(cc) << 24) | (32'(imm) << 23)
             | (32'(dst & 2047) << 11) | 32'(src & 2047);
    endfunction

    function automatic int rb(input int i);
        return 1024 + i * 32;
    endfunction

    function automatic int rr(input int k);
        return (k < 4) ? k : rb(k - 3);
    endfunction

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t1_exp [7];
        int pc;
        t1_exp = '{32'h0000000F, 32'hF0000000, 32'hF0000001, 32'h00000014,
                   32'h00000000, 32'h00000155, 32'h00000000};
        for (int i = 0; i < 2048; i++) m_mem[i] = '0;

        // Reset, then clear the whole memory through the loader.
        halt_and_reset();
        check("reset_result", result, 32'h0);
        check("reset_carry", {31'b0, carry}, 32'h0);
        for (int a = 0; a < 2048; a++) wr(a, 32'h0);

        // T1: reference program.
        wr(1,  enc(7, 0, 0, 3, 30));
        wr(2,  enc(7, 0, 0, rb(3), 31));
        wr(3,  enc(5, 1, 0, 0, 0));
        wr(4,  enc(6, 0, 0, 2046, 3));
        wr(5,  enc(4, 0, 1, rb(3), 1));
        wr(6,  enc(4, 0, 1, 3, 5));
        wr(7,  enc(3, 0, 0, 3, 3));
        wr(8,  enc(1, 0, 1, 7, 341));
        wr(9,  enc(2, 0, 0, 3, 5));
        wr(10, enc(5, 0, 0, 0, 2047));
        wr(30, 32'h0000000F);
        wr(31, 32'hF0000000);
        cap_q.delete();
        cap_last = result;
        cap_on   = 1'b1;
        cpu_en   = 1'b1;
        ticks(40);
        cap_on = 1'b0;
        check("t1_writebacks", 32'(cap_q.size() >= 7), 32'h1);
        for (int i = 0; i < 7; i++) begin
            if (i < cap_q.size()) check($sformatf("t1_wb%0d", i), cap_q[i], t1_exp[i]);
        end
        check("t1_carry", {31'b0, carry}, 32'h0);

        // mem2046 holds the stored A3 value; read it back through a LOAD.
        halt_and_reset();
        wr(1, enc(7, 0, 0, 9, 2046));
        wr(2, enc(5, 0, 0, 0, 2));
        cpu_en = 1'b1;
        ticks(8);
        check("t1_mem2046", result, 32'h0000000F);

        // T2: ADD overflow sets C and Z; taken carry branch skips two ADDs.
        halt_and_reset();
        wr(40, 32'hFFFFFFFF);
        wr(1, enc(7, 0, 0, 0, 40));
        wr(2, enc(4, 0, 1, 0, 1));
        wr(3, enc(5, 2, 0, 0, 6));
        wr(4, enc(4, 0, 1, 5, 7));
        wr(5, enc(4, 0, 1, 6, 9));
        wr(6, enc(5, 1, 0, 0, 8));
        wr(7, enc(4, 0, 1, 5, 7));
        wr(8, enc(5, 0, 0, 0, 8));
        cpu_en = 1'b1;
        ticks(20);
        check("t2_result", result, 32'h0);
        check("t2_carry", {31'b0, carry}, 32'h1);

        // T3: SUB borrow and negative.
        halt_and_reset();
        wr(41, 32'h2);
        wr(1, enc(7, 0, 0, 1, 41));
        wr(2, enc(3, 0, 1, 1, 5));
        wr(3, enc(5, 3, 0, 0, 5));
        wr(4, enc(4, 0, 1, 5, 7));
        wr(5, enc(5, 0, 0, 0, 5));
        cpu_en = 1'b1;
        ticks(16);
        check("t3_result", result, 32'hFFFFFFFD);
        check("t3_carry", {31'b0, carry}, 32'h1);

        // Reset wins over cpu_en=0.
        cpu_en = 1'b0;
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        check("t6_rst_result", result, 32'h0);
        check("t6_rst_carry", {31'b0, carry}, 32'h0);

        // T4/T5/T6: back-to-back forwarding, freeze, mid-program reset.
        for (int a = 1; a <= 6; a++) wr(a, enc(4, 0, 1, 2, 1));
        wr(7, enc(5, 0, 0, 0, 7));
        cpu_en = 1'b1;
        ticks(4);
        check("t4_first", result, 32'h1);
        tick();
        check("t4_second", result, 32'h2);
        cpu_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_frozen", result, 32'h2);
        end
        cpu_en = 1'b1;
        tick();
        check("t5_resume", result, 32'h3);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        check("t6_mid_result", result, 32'h0);
        check("t6_mid_carry", {31'b0, carry}, 32'h0);
        ticks(4);
        check("t6_refetch", result, 32'h1);

        // Randomized programs with random pipeline freezes.
        for (int iter = 0; iter < 3; iter++) begin
            halt_and_reset();
            for (int i = 0; i < 16; i++) begin
                wr(1500 + i, (i == 0) ? 32'hFFFFFFFF : (i == 1) ? 32'h0 : $urandom());
            end
            pc = 1;
            for (int k = 0; k < 6; k++) begin
                wr(pc, enc(7, 0, 0, rr(k), 1500 + k));
                pc++;
            end
            for (int j = 0; j < 40; j++) begin
                int kind, imm;
                kind = int'($urandom_range(0, 9));
                imm  = int'($urandom_range(0, 1));
                if (kind <= 4) begin
                    wr(pc, enc(1 + int'($urandom_range(0, 3)), 0, imm, rr(int'($urandom_range(0, 5))),
                               imm ? int'($urandom_range(0, 2047)) : rr(int'($urandom_range(0, 5)))));
                end else if (kind == 5) begin
                    wr(pc, enc(7, 0, 0, rr(int'($urandom_range(0, 5))), 1500 + int'($urandom_range(0, 15))));
                end else if (kind == 6) begin
                    wr(pc, enc(6, 0, 0, 1508 + int'($urandom_range(0, 7)), rr(int'($urandom_range(0, 5)))));
                end else if (kind == 7) begin
                    wr(pc, enc(5, int'($urandom_range(0, 7)), 0, 0, pc + 2));
                end else begin
                    wr(pc, enc(4, 0, 1, rr(int'($urandom_range(0, 5))), int'($urandom_range(0, 15))));
                end
                pc++;
            end
            wr(pc, enc(5, 0, 0, 0, pc));
            wr(pc + 1, enc(5, 0, 0, 0, pc));
            for (int c = 0; c < 150; c++) begin
                cpu_en = ($urandom_range(0, 4) != 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
